// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C slave with an internal byte memory.
//
// Oversamples SCL/SDA on clk, decodes START/STOP, and serves
// write-address / sequential-write / current-address and random-read
// transfers. Writes wrap inside a page; reads wrap over the whole memory.
// The host side can inspect any byte through a registered read port.
//
// Ports:
//   clk        system clock, at least 8x the SCL frequency
//   rst        synchronous active-high reset
//   scl        I2C clock from the master
//   sda_in     resolved SDA bus level
//   sda_oe     1 = pull SDA low, 0 = release
//   busy       high from an address match until STOP or a non-matching START
//   wr_stb     one-cycle pulse per committed write byte
//   wr_addr    address of the committed byte
//   wr_data    committed byte
//   host_addr  host inspection address
//   host_rdata mem[host_addr], one cycle latency
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus free or reset, waiting for START
// DEV     | shifting in the device address + R/W byte
// WADDR   | receiving the word address of a write
// WDATA   | receiving data bytes, each committed at its ACK slot
// RDATA   | driving a memory byte onto SDA, MSB first
// RACK    | SDA released, sampling the master's ACK/NACK
// IGNORE  | not addressed or read finished, waiting for START/STOP

module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_DEPTH   = 16,
  parameter int         PAGE_SIZE   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scl,
  input  logic                         sda_in,
  output logic                         sda_oe,
  output logic                         busy,
  output logic                         wr_stb,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  input  logic [$clog2(MEM_DEPTH)-1:0] host_addr,
  output logic [7:0]                   host_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEV    = 3'd1;
  localparam logic [2:0] S_WADDR  = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_RACK   = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [2:0]    state;
  logic [3:0]    bit_cnt;
  logic          ack_seen;
  logic          rw_bit;
  logic          m_ack;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_page_next;
  logic [AW-1:0] ptr_full_next;
  logic [7:0]    rd_byte;
  logic [7:0]    mem [MEM_DEPTH];

  // Synchronisers reset to 1 so a reset on an idle bus never looks like
  // an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // Writes advance only the in-page bits; reads advance the whole pointer.
  assign ptr_page_next = (ptr & ~PAGE_MASK) | ((ptr + AW'(1)) & PAGE_MASK);
  assign ptr_full_next = ptr + AW'(1);
  assign rd_byte       = mem[ptr];

  // bit_cnt counts SCL rises within a byte; once it reaches 8 the next
  // fall opens the ACK slot, the following rise sets ack_seen and the fall
  // after that closes the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      ack_seen <= 1'b0;
      rw_bit   <= 1'b0;
      m_ack    <= 1'b0;
      rx_byte  <= '0;
      tx_byte  <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 8'hFF;
      end
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state    <= S_DEV;
        bit_cnt  <= '0;
        ack_seen <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        case (state)
          S_DEV, S_WADDR, S_WDATA: begin
            if (scl_rise) begin
              if (bit_cnt != 4'd8) begin
                rx_byte <= {rx_byte[6:0], sda_s};
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                ack_seen <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (!ack_seen) begin
                // Byte complete: open the ACK slot.
                if (state == S_DEV) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    sda_oe <= 1'b1;
                    busy   <= 1'b1;
                    rw_bit <= rx_byte[0];
                  end else begin
                    state  <= S_IGNORE;
                    busy   <= 1'b0;
                  end
                end else if (state == S_WADDR) begin
                  ptr    <= rx_byte[AW-1:0];
                  sda_oe <= 1'b1;
                end else begin
                  mem[ptr] <= rx_byte;
                  wr_stb   <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= rx_byte;
                  ptr      <= ptr_page_next;
                  sda_oe   <= 1'b1;
                end
              end else begin
                // ACK slot over.
                bit_cnt  <= '0;
                ack_seen <= 1'b0;
                if (state == S_DEV && rw_bit) begin
                  state   <= S_RDATA;
                  tx_byte <= rd_byte;
                  sda_oe  <= ~rd_byte[7];
                  ptr     <= ptr_full_next;
                end else begin
                  sda_oe <= 1'b0;
                  if (state == S_DEV) begin
                    state <= S_WADDR;
                  end else begin
                    state <= S_WDATA;
                  end
                end
              end
            end
          end

          S_RDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe   <= 1'b0;
                ack_seen <= 1'b0;
                state    <= S_RACK;
              end else if (bit_cnt != 4'd0) begin
                tx_byte <= {tx_byte[6:0], 1'b0};
                sda_oe  <= ~tx_byte[6];
              end
            end
          end

          S_RACK: begin
            if (scl_rise) begin
              ack_seen <= 1'b1;
              m_ack    <= ~sda_s;
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              bit_cnt  <= '0;
              if (m_ack) begin
                state   <= S_RDATA;
                tx_byte <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                ptr     <= ptr_full_next;
              end else begin
                state <= S_IGNORE;
              end
            end
          end

          S_IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Same-cycle bus write to host_addr returns the pre-write byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata <= '0;
    end else begin
      host_rdata <= mem[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
module tb_i2c_slave_mem;

  localparam int MEM_DEPTH = 16;
  localparam int PAGE_SIZE = 8;
  localparam int Q         = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       busy;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] host_addr = '0;
  logic [7:0] host_rdata;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_mem #(
    .DEV_ADDR   (7'h50),
    .MEM_DEPTH  (MEM_DEPTH),
    .PAGE_SIZE  (PAGE_SIZE),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .host_addr (host_addr),
    .host_rdata(host_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain byte array plus address pointer.
  logic [7:0]  ref_mem [MEM_DEPTH];
  int          ref_ptr;
  logic [7:0]  tx_q [$];
  logic [11:0] stb_q [$];
  logic [11:0] exp_q [$];

  always @(negedge clk) begin
    if (!rst && wr_stb) stb_q.push_back({wr_addr, wr_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  function automatic int page_next(input int p);
    return (p / PAGE_SIZE) * PAGE_SIZE + ((p % PAGE_SIZE) + 1) % PAGE_SIZE;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 8'hFF;
    ref_ptr = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda_m = 1'b1; quarter();
      scl = 1'b1;   quarter();
    end
    sda_m = 1'b0; quarter();
    scl = 1'b0;   quarter();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; quarter();
    scl = 1'b1;   quarter();
    sda_m = 1'b1; quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; quarter();
      scl = 1'b1;   quarter(); quarter();
      scl = 1'b0;
    end
    sda_m = 1'b1; quarter();
    scl = 1'b1;   quarter();
    ack = !sda_in;
    quarter();
    scl = 1'b0;   quarter();
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      quarter();
      scl = 1'b1; quarter();
      b[i] = sda_in;
      quarter();
      scl = 1'b0;
    end
    sda_m = mack ? 1'b0 : 1'b1; quarter();
    scl = 1'b1; quarter(); quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic host_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk) host_addr = a;
    @(negedge clk);
    check($sformatf("%s host[%0h]", tag, a), host_rdata, exp);
  endtask

  // Write transfer: dev7 + W, word address, then tx_q bytes.
  task automatic xfer_write(input logic [6:0] dev7, input logic [7:0] addr,
                            input bit exp_ack, input string tag);
    bit ack;
    stb_q.delete();
    exp_q.delete();
    bus_start();
    write_byte({dev7, 1'b0}, ack);
    check({tag, " dev ack"}, ack, exp_ack);
    check({tag, " busy"}, busy, exp_ack);
    write_byte(addr, ack);
    check({tag, " addr ack"}, ack, exp_ack);
    if (exp_ack) ref_ptr = addr % MEM_DEPTH;
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      check($sformatf("%s data%0d ack", tag, i), ack, exp_ack);
      if (exp_ack) begin
        exp_q.push_back({4'(ref_ptr), tx_q[i]});
        ref_mem[ref_ptr] = tx_q[i];
        ref_ptr = page_next(ref_ptr);
      end
    end
    bus_stop();
    quarter();
    check({tag, " busy after stop"}, busy, 1'b0);
    check({tag, " wr_stb count"}, stb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
      check($sformatf("%s wr_stb%0d addr/data", tag, i), stb_q[i], exp_q[i]);
  endtask

  // Read transfer, optionally preceded by a word-address write and Sr.
  task automatic xfer_read(input logic [6:0] dev7, input bit set_addr,
                           input logic [7:0] addr, input int n, input string tag);
    bit ack;
    bit exp_ack;
    logic [7:0] b;
    exp_ack = (dev7 == 7'h50);
    bus_start();
    if (set_addr) begin
      write_byte({dev7, 1'b0}, ack);
      check({tag, " wdev ack"}, ack, exp_ack);
      write_byte(addr, ack);
      check({tag, " addr ack"}, ack, exp_ack);
      if (exp_ack) ref_ptr = addr % MEM_DEPTH;
      bus_start();
    end
    write_byte({dev7, 1'b1}, ack);
    check({tag, " rdev ack"}, ack, exp_ack);
    if (exp_ack) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i != n - 1, b);
        check($sformatf("%s byte%0d @%0h", tag, i, ref_ptr), b, ref_mem[ref_ptr]);
        ref_ptr = (ref_ptr + 1) % MEM_DEPTH;
      end
      check({tag, " sda released after nack"}, sda_oe, 1'b0);
      check({tag, " busy before stop"}, busy, 1'b1);
    end
    bus_stop();
    quarter();
    check({tag, " busy after stop"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [6:0] dev7;
    logic [7:0] addr;
    int         n;
    logic [7:0] d [3];
    bit         exp_ack;
    int         exp_stb;
  } wvec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] exp;
  } hvec_t;

  wvec_t wtab [4];
  hvec_t htab [10];

  initial begin
    bit ack;
    logic [6:0] dev;
    int kind;
    int n;

    wtab[0] = '{7'h50, 8'h03, 1, '{8'h5A, 8'h00, 8'h00}, 1'b1, 1};
    wtab[1] = '{7'h50, 8'h06, 3, '{8'h11, 8'h22, 8'h33}, 1'b1, 3};
    wtab[2] = '{7'h51, 8'h00, 1, '{8'h77, 8'h00, 8'h00}, 1'b0, 0};
    wtab[3] = '{7'h50, 8'h0E, 3, '{8'hA1, 8'hB2, 8'hC3}, 1'b1, 3};

    htab[0] = '{4'h3, 8'h5A};
    htab[1] = '{4'h6, 8'h11};
    htab[2] = '{4'h7, 8'h22};
    htab[3] = '{4'h0, 8'h33};
    htab[4] = '{4'h1, 8'hFF};
    htab[5] = '{4'hE, 8'hA1};
    htab[6] = '{4'hF, 8'hB2};
    htab[7] = '{4'h8, 8'hC3};
    htab[8] = '{4'h2, 8'hFF};
    htab[9] = '{4'h4, 8'hFF};

    ref_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst wr_stb", wr_stb, 1'b0);
    check("rst wr_addr", wr_addr, 4'h0);
    check("rst wr_data", wr_data, 8'h00);
    check("rst host_rdata", host_rdata, 8'h00);
    rst = 1'b0;
    quarter();
    for (int i = 0; i < MEM_DEPTH; i++) host_check(4'(i), 8'hFF, "init");

    // Directed write table
    for (int t = 0; t < 4; t++) begin
      tx_q.delete();
      for (int k = 0; k < wtab[t].n; k++) tx_q.push_back(wtab[t].d[k]);
      xfer_write(wtab[t].dev7, wtab[t].addr, wtab[t].exp_ack, $sformatf("wtab%0d", t));
      check($sformatf("wtab%0d stb count", t), stb_q.size(), wtab[t].exp_stb);
    end
    for (int t = 0; t < 10; t++) host_check(htab[t].a, htab[t].exp, "htab");

    // Random read with repeated START, top wrap, current-address read
    xfer_read(7'h50, 1'b1, 8'h02, 3, "rd_sr");
    xfer_read(7'h50, 1'b1, 8'h0F, 2, "rd_wrap");
    xfer_read(7'h50, 1'b0, 8'h00, 1, "rd_cur");
    xfer_read(7'h52, 1'b1, 8'h00, 1, "rd_nomatch");

    // Reset in the middle of a data byte
    stb_q.delete();
    bus_start();
    write_byte(8'hA0, ack);
    check("mid dev ack", ack, 1'b1);
    write_byte(8'h05, ack);
    check("mid addr ack", ack, 1'b1);
    for (int i = 7; i >= 4; i--) begin
      sda_m = (i % 2 == 0); quarter();
      scl = 1'b1; quarter(); quarter();
      scl = 1'b0;
    end
    quarter();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("mid rst sda_oe", sda_oe, 1'b0);
    check("mid rst busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_reset();
    sda_m = 1'b1; quarter();
    scl = 1'b1; quarter(); quarter();
    check("mid no wr_stb", stb_q.size(), 0);
    for (int i = 0; i < MEM_DEPTH; i++) host_check(4'(i), 8'hFF, "after_rst");
    tx_q.delete();
    tx_q.push_back(8'hC3);
    xfer_write(7'h50, 8'h01, 1'b1, "post_rst");
    host_check(4'h1, 8'hC3, "post_rst");

    // Randomised transfers against the model
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 9);
      dev = 7'($urandom_range(0, 127));
      if (dev == 7'h50) dev = 7'h51;
      if (kind <= 4) begin
        tx_q.delete();
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
        if (kind != 0) dev = 7'h50;
        xfer_write(dev, 8'($urandom), dev == 7'h50, $sformatf("rnd%0d wr", t));
      end else begin
        if (kind != 9) dev = 7'h50;
        xfer_read(dev, kind != 8, 8'($urandom), $urandom_range(1, 4),
                  $sformatf("rnd%0d rd", t));
      end
    end
    for (int i = 0; i < MEM_DEPTH; i++) host_check(4'(i), ref_mem[i], "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_mem.md
Name: i2c_slave_mem

Overview:
- Parametrised, synthesisable I2C slave with an internal byte memory.
- Successor to the behavioural EEPROM slave used in the i2c master benches.
- Adds read transfers, page-wrap writes, repeated START, address NACK, and a host-side inspection port.
- Sits on the same SDA/SCL bus as the i2c master; oversamples the bus on the system clock.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address (8'hA0 write / 8'hA1 read on the wire).
- MEM_DEPTH, 16, number of bytes in memory; power of two, 2..256.
- PAGE_SIZE, 16, write-wrap page in bytes; power of two, at most MEM_DEPTH.
- SYNC_STAGES, 2, synchroniser flops on scl and sda_in; at least 2.

Ports:
- clk  in  1  system clock; at least 8x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl  in  1  I2C clock from the master.
- sda_in  in  1  resolved SDA bus level.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The top level builds the open-drain pad.
- busy  out  1  high from an address match until STOP, or until the next START that fails to match.
- wr_stb  out  1  one-cycle pulse per committed write byte.
- wr_addr  out  $clog2(MEM_DEPTH)  address of the committed byte.
- wr_data  out  8  committed byte.
- host_addr  in  $clog2(MEM_DEPTH)  host inspection address.
- host_rdata  out  8  mem[host_addr], registered, 1-cycle latency.

Behaviour:
- Reset:
  - sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, host_rdata=0.
  - ptr=0, state IDLE, every memory byte set to 8'hFF.
  - Reset mid-transfer aborts immediately; the slave waits for the next START.
- Bus sampling:
  - scl and sda_in pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised values.
  - START = sda fall while scl high. STOP = sda rise while scl high.
  - START/STOP take priority over bit processing in the same cycle.
- Bit timing:
  - Received bits are sampled on SCL rise, MSB first.
  - sda_oe changes only in the cycle after an SCL fall.
- Bit counter: 0..8; bit 8 is the ACK slot.
- States: IDLE, DEV, WADDR, WDATA, RDATA, RACK, IGNORE.
- IDLE: waits for START, then goes to DEV.
- DEV:
  - Shifts in 8 bits.
  - Upper 7 bits == DEV_ADDR: ACK (sda_oe=1 from the SCL fall after bit 7 until the SCL fall after the ACK), busy=1.
    - R/W=0: go to WADDR.
    - R/W=1: go to RDATA.
  - Mismatch: no ACK, busy=0, go to IGNORE.
- WADDR:
  - Receives the byte and ACKs it.
  - ptr = byte mod MEM_DEPTH; go to WDATA.
- WDATA:
  - Receives the byte and ACKs it.
  - At the SCL fall that begins the ACK: mem[ptr] <= byte; wr_stb pulses 1 cycle with wr_addr=ptr and wr_data=byte.
  - ptr increments within the page only: upper bits hold, lower $clog2(PAGE_SIZE) bits wrap.
- RDATA:
  - Drives mem[ptr] MSB first. sda_oe = ~bit, updated after each SCL fall; the first bit is set after the SCL fall that ends the address ACK.
  - After bit 7, releases SDA and goes to RACK.
  - ptr increments mod MEM_DEPTH (full wrap, not page wrap).
- RACK:
  - Master ACK (SDA=0 at SCL rise): load the next byte, go to RDATA.
  - Master NACK: go to IGNORE.
- IGNORE: sda_oe=0 and held; waits for START or STOP.
- Any state:
  - STOP: go to IDLE, sda_oe=0, busy=0. ptr is retained, so a later current-address read continues from it.
  - START (including repeated START): go to DEV, reset the bit counter, sda_oe=0. ptr is retained, so a write-address then repeated-START read works.
- A write byte that is interrupted before its 8th bit is discarded (no commit, no wr_stb).
- Host port: host_rdata <= mem[host_addr] every cycle. A bus write and a host read to the same address in the same cycle returns the old data.

Test Plan:
- Single-byte write: START, A0, 03, 5A, STOP -> three ACKs; wr_stb once with wr_addr=3, wr_data=5A; host_addr=3 reads 5A; all other bytes FF.
- Sequential write with page wrap, PAGE_SIZE=8: A0, 06, then 11 22 33 -> mem[6]=11, mem[7]=22, mem[0]=33; three wr_stb pulses.
- Random read with repeated START: A0, 02, Sr, A1; master ACKs 2 bytes and NACKs the 3rd -> data mem[2], mem[3], mem[4]; SDA released after the NACK; busy drops at STOP.
- Read wraps at the top: ptr=0F, read 2 bytes -> mem[F] then mem[0].
- Address mismatch: START, A2, 00, 77, STOP -> no ACK on any byte (SDA high at every 9th SCL); no wr_stb; memory unchanged; busy stays 0.
- Reset mid-write: rst asserted after 4 bits of a data byte -> sda_oe=0 next cycle; that byte not written; all memory FF; the next A0/01/C3 transfer writes mem[1]=C3.
